// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with bubble/flush/hold sequencing and bubble watchdog.
// Optional perf counters enabled by defining ID_EX_PERF_EN.
module id_ex_pipe_reg #(
    parameter int XLEN        = 32,
    parameter int CTRL_W      = 8,
    parameter int MAX_BUBBLES = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [XLEN-1:0]   i_id_rs1_data,
    input  logic [XLEN-1:0]   i_id_rs2_data,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [4:0]        i_id_rs1,
    input  logic [4:0]        i_id_rs2,
    input  logic [4:0]        i_id_rd,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_read,
    input  logic              i_id_mem_write,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic              i_bubble_id_ex,
    input  logic              i_flush_id_ex,
    input  logic              i_hold_ex,
    output logic              o_ex_valid,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [XLEN-1:0]   o_ex_rs1_data,
    output logic [XLEN-1:0]   o_ex_rs2_data,
    output logic [XLEN-1:0]   o_ex_imm,
    output logic [4:0]        o_ex_rs1,
    output logic [4:0]        o_ex_rs2,
    output logic [4:0]        o_ex_rd,
    output logic              o_ex_reg_write,
    output logic              o_ex_mem_read,
    output logic              o_ex_mem_write,
    output logic [CTRL_W-1:0] o_ex_ctrl,
    output logic [1:0]        o_state,
    output logic [7:0]        o_consec_bubbles,
    output logic              o_timeout
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       o_perf_bubbles,
    output logic [31:0]       o_perf_holds
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] LP_MAX = 8'(MAX_BUBBLES);

    state_t            r_state;
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [CTRL_W-1:0] r_ctrl;
    logic [7:0]        r_cnt;
    logic              r_timeout;

    logic              w_kill;
    logic              w_load;
    logic              w_bub_kill;
    logic              w_flush_clr;
    logic [7:0]        w_cnt_nxt;
    state_t            w_state_nxt;

    assign w_kill      = i_bubble_id_ex | i_flush_id_ex | ~i_id_valid;
    assign w_load      = ~i_hold_ex & ~w_kill;
    assign w_bub_kill  = ~i_hold_ex & i_bubble_id_ex;
    assign w_flush_clr = ~i_hold_ex & i_flush_id_ex & ~i_bubble_id_ex;

    // Invalid-ID kills neither count nor clear the bubble run.
    always_comb begin
        w_cnt_nxt = r_cnt;
        unique case (1'b1)
            i_hold_ex:
                w_cnt_nxt = r_cnt;
            w_bub_kill:
                w_cnt_nxt = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
            w_load, w_flush_clr:
                w_cnt_nxt = 8'd0;
            default:
                w_cnt_nxt = r_cnt;
        endcase
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        if (i_hold_ex)
            w_state_nxt = ST_HOLD;
        else if (i_bubble_id_ex)
            w_state_nxt = ST_BUBBLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_RUN;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= r_timeout | (w_cnt_nxt >= LP_MAX);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || (!i_hold_ex && w_kill)) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ctrl      <= '0;
        end else if (w_load) begin
            r_valid     <= 1'b1;
            r_pc        <= i_id_pc;
            r_rs1_data  <= i_id_rs1_data;
            r_rs2_data  <= i_id_rs2_data;
            r_imm       <= i_id_imm;
            r_rs1       <= i_id_rs1;
            r_rs2       <= i_id_rs2;
            r_rd        <= i_id_rd;
            r_reg_write <= i_id_reg_write;
            r_mem_read  <= i_id_mem_read;
            r_mem_write <= i_id_mem_write;
            r_ctrl      <= i_id_ctrl;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] r_perf_bubbles;
    logic [31:0] r_perf_holds;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_bubbles <= '0;
            r_perf_holds   <= '0;
        end else begin
            if (w_bub_kill)
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            if (i_hold_ex)
                r_perf_holds <= r_perf_holds + 32'd1;
        end
    end

    assign o_perf_bubbles = r_perf_bubbles;
    assign o_perf_holds   = r_perf_holds;
`endif

    assign o_ex_valid       = r_valid;
    assign o_ex_pc          = r_pc;
    assign o_ex_rs1_data    = r_rs1_data;
    assign o_ex_rs2_data    = r_rs2_data;
    assign o_ex_imm         = r_imm;
    assign o_ex_rs1         = r_rs1;
    assign o_ex_rs2         = r_rs2;
    assign o_ex_rd          = r_rd;
    assign o_ex_reg_write   = r_reg_write;
    assign o_ex_mem_read    = r_mem_read;
    assign o_ex_mem_write   = r_mem_write;
    assign o_ex_ctrl        = r_ctrl;
    assign o_state          = r_state;
    assign o_consec_bubbles = r_cnt;
    assign o_timeout        = r_timeout;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register and its stall sequencer; it is the consumer of the hazard unit's stall/bubble requests.
- Latches decoded ID-stage fields into EX each cycle.
- Converts the hazard unit's bubble request or an ID-stage flush into a NOP.
- Freezes its contents while the back end is held.
- Tracks consecutive bubbles with a watchdog so a livelocked hazard loop is flagged.

Parameters:
XLEN, 32, data/PC width
CTRL_W, 8, width of opaque EX/MEM/WB control bundle (ALU op, wb select, etc.)
MAX_BUBBLES, 15, consecutive-bubble threshold that raises timeout (1..255)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_id_valid  in  1  ID instruction valid
i_id_pc  in  XLEN  ID PC
i_id_rs1_data  in  XLEN  rs1 operand
i_id_rs2_data  in  XLEN  rs2 operand
i_id_imm  in  XLEN  immediate
i_id_rs1  in  5  rs1 index
i_id_rs2  in  5  rs2 index
i_id_rd  in  5  rd index
i_id_reg_write  in  1  writes rd
i_id_mem_read  in  1  load
i_id_mem_write  in  1  store
i_id_ctrl  in  CTRL_W  control bundle
i_bubble_id_ex  in  1  hazard unit bubble request
i_flush_id_ex  in  1  kill ID instruction (redirect)
i_hold_ex  in  1  back end stalled (dcache busy); EX must not advance
o_ex_valid  out  1  EX instruction valid
o_ex_pc  out  XLEN  EX copy of i_id_pc
o_ex_rs1_data  out  XLEN  EX copy of i_id_rs1_data
o_ex_rs2_data  out  XLEN  EX copy of i_id_rs2_data
o_ex_imm  out  XLEN  EX copy of i_id_imm
o_ex_rs1  out  5  EX copy of i_id_rs1
o_ex_rs2  out  5  EX copy of i_id_rs2
o_ex_rd  out  5  EX copy of i_id_rd
o_ex_reg_write  out  1  EX copy of i_id_reg_write
o_ex_mem_read  out  1  EX copy of i_id_mem_read
o_ex_mem_write  out  1  EX copy of i_id_mem_write
o_ex_ctrl  out  CTRL_W  EX copy of i_id_ctrl
o_state  out  2  FSM state (debug)
o_consec_bubbles  out  8  saturating consecutive-bubble count
o_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: every o_ex_* output = 0; o_state = RUN; o_consec_bubbles = 0; o_timeout = 0; perf counters = 0. Reset mid-operation discards held contents immediately.
- Per-edge action priority: reset > HOLD > KILL > LOAD.
  - HOLD (i_hold_ex=1): every o_ex_* register keeps its value, even if bubble/flush is asserted the same cycle.
  - KILL (i_bubble_id_ex | i_flush_id_ex | !i_id_valid):
    - o_ex_valid, reg_write, mem_read, mem_write, ctrl = 0.
    - rd/rs1/rs2 = 0; data, imm and pc fields = 0.
  - LOAD: all o_ex_* = corresponding i_id_*; o_ex_valid = 1.
- Latency: one cycle, ID field to EX output.
- FSM (o_state encoding RUN=0, BUBBLE=1, HOLD=2), next state:
  - HOLD if i_hold_ex.
  - BUBBLE if i_bubble_id_ex (flush alone gives RUN).
  - RUN otherwise.
- Consecutive-bubble count:
  - Increments on each edge where a KILL is caused by i_bubble_id_ex without hold.
  - Unchanged during HOLD.
  - Cleared on LOAD, or on a flush without bubble.
  - Saturates at 255.
- o_timeout: set when the count reaches MAX_BUBBLES (in the same edge); stays 1 until i_rst.
- Bubble and flush together: a single KILL; counted as a bubble.

Optional Feature:
Macro: ID_EX_PERF_EN.
- Defined:
  - Adds outputs o_perf_bubbles[31:0] (KILL edges caused by i_bubble_id_ex) and o_perf_holds[31:0] (edges with i_hold_ex=1).
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then LOAD: i_rst 1 cycle, then i_id_valid=1, pc=0x100, rd=5, reg_write=1 → next cycle o_ex_valid=1, o_ex_pc=0x100, o_ex_rd=5, o_state=RUN.
- Load-use bubble: i_bubble_id_ex=1 for one cycle with valid ID rd=7, mem_read=1 → o_ex_valid=0, o_ex_reg_write=0, o_ex_mem_read=0, o_ex_rd=0, o_state=BUBBLE, o_consec_bubbles=1; next LOAD clears count to 0.
- Hold beats bubble: EX holds pc=0x200; assert i_hold_ex=1 and i_bubble_id_ex=1 for 3 cycles → o_ex_pc stays 0x200, o_ex_valid stays 1, o_state=HOLD, count unchanged.
- Flush: i_flush_id_ex=1 with valid ID mem_write=1 → o_ex_valid=0, o_ex_mem_write=0, o_state=RUN.
- Watchdog: MAX_BUBBLES=4, bubble held 4 cycles → o_timeout=1 after 4th edge. Drop bubble → o_timeout stays 1 until i_rst.
- Mid-hold reset, plus perf counters (ID_EX_PERF_EN): i_rst during HOLD → all outputs 0 next cycle. Then 2 bubbles and 3 holds → o_perf_bubbles=2, o_perf_holds=3.
